// File: rtl/fifo_uart_tx.sv
// Drains a synchronous FIFO one word at a time and serialises each word as a
// UART frame: start bit, DATA_WIDTH data bits LSB first, STOP_BITS stop bits.
module fifo_uart_tx #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16,
    parameter int STOP_BITS    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  tx_en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_r_en,
    output logic                  tx,
    output logic                  busy,
    output logic                  tx_done
);

    localparam int BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W  = $clog2(DATA_WIDTH + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [BIT_W-1:0]  DATA_LAST = BIT_W'(DATA_WIDTH - 1);
    localparam logic [BIT_W-1:0]  STOP_LAST = BIT_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_READ  = 3'd1,
        S_LATCH = 3'd2,
        S_START = 3'd3,
        S_DATA  = 3'd4,
        S_STOP  = 3'd5
    } state_t;

    state_t                 state_r, state_s;
    logic [BAUD_W-1:0]      baud_r, baud_s;
    logic [BIT_W-1:0]       bit_r, bit_s;
    logic [DATA_WIDTH-1:0]  shift_r, shift_s;
    logic                   tx_r, tx_s;
    logic                   ren_r, ren_s;
    logic                   busy_r, busy_s;
    logic                   done_r, done_s;
    logic                   baud_end_s;

    // State, counters and all outputs are registered here.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r <= S_IDLE;
            baud_r  <= '0;
            bit_r   <= '0;
            shift_r <= '0;
            tx_r    <= 1'b1;
            ren_r   <= 1'b0;
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            baud_r  <= baud_s;
            bit_r   <= bit_s;
            shift_r <= shift_s;
            tx_r    <= tx_s;
            ren_r   <= ren_s;
            busy_r  <= busy_s;
            done_r  <= done_s;
        end
    end

    // Next-state and next-output logic; the bit counter doubles as the
    // stop-bit counter because the baud counter cannot span two stop bits.
    always_comb begin
        state_s    = state_r;
        baud_s     = baud_r;
        bit_s      = bit_r;
        shift_s    = shift_r;
        tx_s       = tx_r;
        ren_s      = 1'b0;
        busy_s     = busy_r;
        done_s     = 1'b0;
        baud_end_s = (baud_r == BAUD_LAST);

        case (state_r)
            S_IDLE: begin
                tx_s   = 1'b1;
                baud_s = '0;
                bit_s  = '0;
                if (tx_en && !fifo_empty) begin
                    ren_s   = 1'b1;
                    busy_s  = 1'b1;
                    state_s = S_READ;
                end else begin
                    busy_s  = 1'b0;
                    state_s = S_IDLE;
                end
            end
            S_READ: begin
                state_s = S_LATCH;
            end
            S_LATCH: begin
                shift_s = fifo_rdata;
                tx_s    = 1'b0;
                baud_s  = '0;
                bit_s   = '0;
                state_s = S_START;
            end
            S_START: begin
                if (baud_end_s) begin
                    tx_s    = shift_r[0];
                    baud_s  = '0;
                    bit_s   = '0;
                    state_s = S_DATA;
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            S_DATA: begin
                if (baud_end_s) begin
                    baud_s = '0;
                    if (bit_r == DATA_LAST) begin
                        tx_s    = 1'b1;
                        bit_s   = '0;
                        state_s = S_STOP;
                    end else begin
                        shift_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
                        tx_s    = shift_r[1];
                        bit_s   = bit_r + BIT_W'(1);
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            S_STOP: begin
                if (baud_end_s) begin
                    baud_s = '0;
                    if (bit_r == STOP_LAST) begin
                        done_s  = 1'b1;
                        busy_s  = 1'b0;
                        bit_s   = '0;
                        state_s = S_IDLE;
                    end else begin
                        bit_s = bit_r + BIT_W'(1);
                    end
                end else begin
                    baud_s = baud_r + BAUD_W'(1);
                end
            end
            default: begin
                state_s = S_IDLE;
                tx_s    = 1'b1;
                busy_s  = 1'b0;
                baud_s  = '0;
                bit_s   = '0;
            end
        endcase
    end

    assign fifo_r_en = ren_r;
    assign tx        = tx_r;
    assign busy      = busy_r;
    assign tx_done   = done_r;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Randomised bench for fifo_uart_tx: a queue-based FIFO feeds the DUT and a
// line decoder checks every frame against the words the FIFO handed out.
module tb_fifo_uart_tx;

    localparam int CPB   = 4;
    localparam int DW    = 8;
    localparam int SB    = 1;
    localparam int FRAME = (1 + DW + SB) * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       tx_en = 1'b0;
    logic       fifo_empty = 1'b1;
    logic [7:0] fifo_rdata = 8'h00;
    logic       fifo_r_en, tx, busy, tx_done;

    logic       tx_en2 = 1'b0;
    logic       fifo_empty2 = 1'b1;
    logic [7:0] fifo_rdata2 = 8'h00;
    logic       fifo_r_en2, tx2, busy2, tx_done2;

    always #5 clk = ~clk;

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(SB)) dut (
        .clk(clk), .rst(rst), .tx_en(tx_en), .fifo_empty(fifo_empty),
        .fifo_rdata(fifo_rdata), .fifo_r_en(fifo_r_en), .tx(tx),
        .busy(busy), .tx_done(tx_done)
    );

    fifo_uart_tx #(.DATA_WIDTH(DW), .CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_sb2 (
        .clk(clk), .rst(rst), .tx_en(tx_en2), .fifo_empty(fifo_empty2),
        .fifo_rdata(fifo_rdata2), .fifo_r_en(fifo_r_en2), .tx(tx2),
        .busy(busy2), .tx_done(tx_done2)
    );

    int         n_vec = 0;
    int         n_err = 0;
    int         cyc = 0;
    logic [7:0] fq[$];
    logic [7:0] exp_q[$];
    int         starts[$];
    bit         pending = 1'b0;
    bit         in_frame = 1'b0;
    int         ren_cyc = 0;
    int         start_cyc = 0;
    int         frames = 0;
    int         ren_cnt = 0;
    logic [7:0] got = 8'h00;
    logic [7:0] last_byte = 8'h00;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic push(input logic [7:0] b);
        fq.push_back(b);
        fifo_empty = 1'b0;
    endtask

    // One clock: FIFO model reacts to r_en, then the line decoder checks outputs.
    task automatic step();
        logic ren_b, empty_b, txen_b, rst_b;
        int   off, idx;
        bit   handled;
        ren_b   = fifo_r_en;
        empty_b = fifo_empty;
        txen_b  = tx_en;
        rst_b   = rst;
        handled = 1'b0;
        @(posedge clk);
        #1;
        cyc++;
        if (ren_b === 1'b1 && fq.size() > 0) begin
            fifo_rdata = fq.pop_front();
            exp_q.push_back(fifo_rdata);
        end else begin
            fifo_rdata = 8'($urandom);
        end
        fifo_empty = (fq.size() == 0);
        if (rst_b === 1'b0) begin
            check_eq("reset_outs", {tx, fifo_r_en, busy, tx_done}, 4'b1000);
            pending  = 1'b0;
            in_frame = 1'b0;
            exp_q.delete();
        end else begin
            if (fifo_r_en === 1'b1) begin
                check_eq("ren_gate", {txen_b, empty_b, pending, tx_done}, 4'b1000);
                pending = 1'b1;
                ren_cyc = cyc;
                ren_cnt++;
            end
            if (in_frame) begin
                off = cyc - start_cyc;
                if (tx_done === 1'b1) begin
                    handled = 1'b1;
                    check_eq("frame_len", off, FRAME);
                    check_eq("busy_at_done", busy, 1'b0);
                    if (exp_q.size() == 0) begin
                        check_eq("byte_unexpected", got, 32'hFFFF_FFFF);
                    end else begin
                        check_eq("byte", got, exp_q.pop_front());
                    end
                    last_byte = got;
                    frames++;
                    in_frame = 1'b0;
                    pending  = 1'b0;
                end else if (off > FRAME) begin
                    check_eq("done_missing", off, FRAME);
                    in_frame = 1'b0;
                    pending  = 1'b0;
                end else if (off % CPB == CPB / 2) begin
                    idx = off / CPB;
                    check_eq("busy_in_frame", busy, 1'b1);
                    if (idx == 0) begin
                        check_eq("start_bit", tx, 1'b0);
                    end else if (idx <= DW) begin
                        got[idx-1] = tx;
                    end else begin
                        check_eq("stop_bit", tx, 1'b1);
                    end
                end
            end else if (pending && tx === 1'b0) begin
                in_frame  = 1'b1;
                start_cyc = cyc;
                starts.push_back(cyc);
                got = 8'h00;
                check_eq("start_latency", cyc - ren_cyc, 2);
            end
            if (!pending && !in_frame) begin
                check_eq("idle_line", {tx, busy, tx_done & ~handled}, 3'b100);
            end
        end
    endtask

    task automatic run(input int n);
        repeat (n) step();
    endtask

    task automatic wait_data_bit(input int bitn);
        int n;
        n = 0;
        while (!(in_frame && (cyc - start_cyc) == (1 + bitn) * CPB + 1) && n < 300) begin
            step();
            n++;
        end
        check_eq("wait_bit", (n < 300), 1'b1);
    endtask

    int f0, r0, pushed, n, first_low, lows, done_i;

    initial begin
        // Reset held with work available; first edge after release reads.
        rst   = 1'b0;
        tx_en = 1'b1;
        push(8'hA5);
        run(2);
        rst = 1'b1;
        step();
        check_eq("ren_after_rst", fifo_r_en, 1'b1);
        run(50);
        check_eq("single_frames", frames, 1);
        check_eq("single_ren", ren_cnt, 1);
        check_eq("single_byte", last_byte, 8'hA5);
        check_eq("single_empty", {fifo_empty, busy}, 2'b10);

        // Back-to-back burst of four words.
        f0 = frames; r0 = ren_cnt;
        starts.delete();
        push(8'hA5); push(8'h5A); push(8'h3C); push(8'hC3);
        run(4 * (FRAME + 3) + 20);
        check_eq("burst_frames", frames - f0, 4);
        check_eq("burst_ren", ren_cnt - r0, 4);
        check_eq("burst_starts", starts.size(), 4);
        if (starts.size() == 4) begin
            for (int i = 1; i < 4; i++) check_eq("burst_spacing", starts[i] - starts[i-1], FRAME + 3);
        end

        // Empty FIFO and tx_en gating.
        r0 = ren_cnt;
        run(100);
        check_eq("empty_no_ren", ren_cnt - r0, 0);
        tx_en = 1'b0;
        push(8'h11); push(8'h22);
        run(50);
        check_eq("txen_off_no_ren", ren_cnt - r0, 0);
        f0 = frames;
        tx_en = 1'b1;
        wait_data_bit(3);
        tx_en = 1'b0;
        run(60);
        check_eq("drop_frames", frames - f0, 1);
        check_eq("drop_ren", ren_cnt - r0, 1);
        check_eq("drop_byte", last_byte, 8'h11);
        check_eq("drop_left", fq.size(), 1);
        tx_en = 1'b1;
        run(50);
        check_eq("drain_byte", last_byte, 8'h22);

        // Reset during data bit 5 of 3C; C3 follows, 3C is lost.
        push(8'h3C); push(8'hC3);
        wait_data_bit(5);
        rst = 1'b0;
        step();
        check_eq("midrst_line", {tx, busy}, 2'b10);
        rst = 1'b1;
        f0 = frames;
        run(60);
        check_eq("midrst_frames", frames - f0, 1);
        check_eq("midrst_byte", last_byte, 8'hC3);
        check_eq("midrst_fifo", fq.size(), 0);

        // Random traffic with random tx_en, then drain.
        f0 = frames; pushed = 0;
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 59) == 0) begin
                push(8'($urandom));
                pushed++;
            end
            tx_en = ($urandom_range(0, 3) != 0);
            step();
        end
        tx_en = 1'b1;
        n = 0;
        while ((fq.size() != 0 || pending || busy) && n < 4000) begin
            step();
            n++;
        end
        run(5);
        check_eq("rand_drained", fq.size(), 0);
        check_eq("rand_frames", frames - f0, pushed);
        tx_en = 1'b0;

        // Two stop bits, all-ones word.
        fifo_rdata2 = 8'hFF;
        fifo_empty2 = 1'b0;
        tx_en2      = 1'b1;
        n = 0;
        while (fifo_r_en2 !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check_eq("sb2_ren", fifo_r_en2, 1'b1);
        first_low = -1; lows = 0; done_i = -1;
        for (int i = 0; i < 55; i++) begin
            if (tx2 === 1'b0) begin
                lows++;
                if (first_low < 0) first_low = i;
            end
            if (tx_done2 === 1'b1 && done_i < 0) done_i = i;
            step();
            if (i == 0) begin
                fifo_empty2 = 1'b1;
                tx_en2      = 1'b0;
            end
        end
        check_eq("sb2_start", first_low, 2);
        check_eq("sb2_low_cycles", lows, CPB);
        check_eq("sb2_done", done_i - first_low, (1 + DW + 2) * CPB);
        check_eq("sb2_end", {tx2, busy2, fifo_r_en2}, 3'b100);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
